// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array tile-pass sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    WAIT1,
    RESULT
  } sa_state_e;

  // Zero vectors needed to flush the diagonal skew out of a TILE_DIM array.
  function automatic int unsigned drain_cycles(input int unsigned tile_dim);
    return 2 * tile_dim - 1;
  endfunction

endpackage

// File: rtl/sa_step_counter.sv
// Up-counter with synchronous clear-load, enable and terminal-count compare.
module sa_step_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc_c
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == last);

endmodule

// File: rtl/systolic_ctrl.sv
// Sequences one systolic tile pass: clear, feed k vectors, drain skew, hand off result.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned TILE_DIM = 64,
  parameter int unsigned K_W      = 16,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic              stall,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              arr_clr_n,
  output logic              arr_enb,
  output logic              zero_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done
);

  localparam int unsigned D  = drain_cycles(TILE_DIM);
  localparam int unsigned DW = $clog2(D + 1);

  sa_state_e      state;
  logic [K_W-1:0] k_lat;
  logic [K_W-1:0] feed_cnt;
  logic [DW-1:0]  drain_cnt;
  logic           feed_tc;
  logic           drain_tc;
  logic           step;
  logic           accept;
  logic           feed_en;
  logic           drain_en;

  // Progress qualifiers; rd_en must drop in the same cycle a stall appears.
  always_comb begin
    step     = ((state == FEED) || (state == DRAIN)) && !stall;
    accept   = (state == IDLE) && start && (k_len != '0);
    feed_en  = step && (state == FEED) && !feed_tc;
    drain_en = step && (state == DRAIN) && !drain_tc;
  end

  assign rd_en   = step && (state == FEED);
  assign rd_addr = ADDR_W'(feed_cnt);

  sa_step_counter #(.W(K_W)) u_feed_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .en    (feed_en),
    .last  (k_lat - K_W'(1)),
    .count (feed_cnt),
    .tc_c  (feed_tc)
  );

  sa_step_counter #(.W(DW)) u_drain_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .en    (drain_en),
    .last  (DW'(D - 1)),
    .count (drain_cnt),
    .tc_c  (drain_tc)
  );

  // Array enables trail the buffer read by one cycle to match its read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k_lat     <= '0;
      busy      <= 1'b0;
      arr_clr_n <= 1'b1;
      arr_enb   <= 1'b0;
      zero_sel  <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      arr_clr_n <= 1'b1;
      arr_enb   <= step;
      zero_sel  <= step && (state == DRAIN);
      case (state)
        IDLE: begin
          if (accept) begin
            k_lat     <= k_len;
            busy      <= 1'b1;
            arr_clr_n <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= FEED;
        FEED: begin
          if (step && feed_tc) state <= DRAIN;
        end
        DRAIN: begin
          if (step && drain_tc) state <= WAIT1;
        end
        WAIT1: begin
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with an address scoreboard and per-cycle output timing.
module tb_systolic_ctrl;

  localparam int unsigned TILE_DIM = 4;
  localparam int unsigned K_W      = 16;
  localparam int unsigned ADDR_W   = 10;
  localparam int          D        = 2 * TILE_DIM - 1;
  localparam logic [6:0]  RST_VEC  = 7'b0010000;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [K_W-1:0]    k_len = '0;
  logic              stall = 1'b0;
  logic              res_ready = 1'b0;
  logic              busy, rd_en, arr_clr_n, arr_enb, zero_sel, res_valid, done;
  logic [ADDR_W-1:0] rd_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int addr_q[$];

  always #5 clk = ~clk;

  systolic_ctrl #(.TILE_DIM(TILE_DIM), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .k_len     (k_len),
    .stall     (stall),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .arr_clr_n (arr_clr_n),
    .arr_enb   (arr_enb),
    .zero_sel  (zero_sel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .done      (done)
  );

  function automatic logic [6:0] outs();
    return {busy, rd_en, arr_clr_n, arr_enb, zero_sel, res_valid, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive the command in the cycle before the accepting edge and queue its addresses.
  task automatic do_start(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = K_W'(k);
    for (int i = 0; i < k; i++) addr_q.push_back(i);
  endtask

  // Walk one pass cycle by cycle from cycle 1; expectations come from the list of step cycles.
  task automatic run_pass(input int k, input logic [63:0] smask, input int rwait,
                          input bit mid_start, input int next_k, input int abort_at,
                          input int exp_rv);
    int scyc[64];
    int n, last_c, rv_c, hs_c, rd_cnt, enb_cnt, first_rv, a;
    logic [6:0] e;
    n = 0; last_c = 0; rd_cnt = 0; enb_cnt = 0; first_rv = -1;
    for (int c = 0; c < 64; c++) scyc[c] = -1;
    for (int c = 2; c < 64 && n < k + D; c++) begin
      if (!smask[c]) begin
        scyc[c] = n;
        n++;
        last_c = c;
      end
    end
    rv_c = last_c + 2;
    hs_c = rv_c + rwait;
    for (int c = 1; c <= hs_c + 2; c++) begin
      @(negedge clk);
      if (mid_start && (c == 3 || c == 7)) begin
        start = 1'b1;
        k_len = K_W'(9);
      end else begin
        start = 1'b0;
      end
      stall     = smask[c];
      res_ready = (rwait == 0) ? 1'b1 : (c >= hs_c);
      if (c == hs_c + 1) begin
        chk($sformatf("k=%0d scoreboard drained", k), 32'(addr_q.size()), 32'd0);
        if (next_k != 0) begin
          start = 1'b1;
          k_len = K_W'(next_k);
          for (int i = 0; i < next_k; i++) addr_q.push_back(i);
        end
      end
      #1;
      e = {c <= hs_c,
           scyc[c] >= 0 && scyc[c] < k,
           c != 1,
           scyc[c-1] >= 0,
           scyc[c-1] >= k,
           c >= rv_c && c <= hs_c,
           c == hs_c + 1};
      chk($sformatf("k=%0d cyc%0d {busy,rd_en,clr_n,enb,zsel,rv,done}", k, c),
          32'(outs()), 32'(e));
      if (rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          chk($sformatf("k=%0d cyc%0d rd_en with no queued address", k, c), 32'd1, 32'd0);
        end else begin
          a = addr_q.pop_front();
          chk($sformatf("k=%0d cyc%0d rd_addr", k, c), 32'(rd_addr), 32'(a));
        end
      end
      if (arr_enb) enb_cnt++;
      if (res_valid && first_rv < 0) first_rv = c;
      if (c == abort_at) begin
        #1 rstn = 1'b0;
        #1;
        chk("async reset outputs", 32'(outs()), 32'(RST_VEC));
        chk("async reset rd_addr", 32'(rd_addr), 32'd0);
        addr_q.delete();
        return;
      end
      if (next_k != 0 && c == hs_c + 1) break;
    end
    chk($sformatf("k=%0d rd_en pulses", k), 32'(rd_cnt), 32'(k));
    chk($sformatf("k=%0d arr_enb cycles", k), 32'(enb_cnt), 32'(k + D));
    if (exp_rv != 0) chk($sformatf("k=%0d res_valid cycle", k), 32'(first_rv), 32'(exp_rv));
  endtask

  initial begin
    logic [63:0] m2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state outputs", 32'(outs()), 32'(RST_VEC));
    chk("reset state rd_addr", 32'(rd_addr), 32'd0);
    rstn = 1'b1;

    // Plain pass, res_ready already high before res_valid.
    do_start(3);
    run_pass(3, 64'd0, 0, 1'b0, 0, 0, 13);

    // Stalls in cycles 3-4 and 8.
    m2 = '0;
    m2[3] = 1'b1; m2[4] = 1'b1; m2[8] = 1'b1;
    do_start(3);
    run_pass(3, m2, 0, 1'b0, 0, 0, 16);

    // Consumer withholds res_ready for 5 cycles.
    do_start(3);
    run_pass(3, 64'd0, 5, 1'b0, 0, 0, 13);

    // Zero-length command is ignored.
    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1 chk($sformatf("k_len=0 idle cyc%0d", i), 32'(outs()), 32'(RST_VEC));
    end

    // Mid-pass start pulses are ignored.
    do_start(3);
    run_pass(3, 64'd0, 0, 1'b1, 0, 0, 13);

    // Reset in cycle 6 aborts; nothing completes afterwards.
    do_start(3);
    run_pass(3, 64'd0, 0, 1'b0, 0, 6, 0);
    start = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset held outputs", 32'(outs()), 32'(RST_VEC));
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1 chk($sformatf("post-abort quiet cyc%0d", i), 32'(outs()), 32'(RST_VEC));
    end
    do_start(3);
    run_pass(3, 64'd0, 0, 1'b0, 0, 0, 13);

    // Back-to-back: k=2 then k=5 started in the done cycle.
    do_start(2);
    run_pass(2, 64'd0, 0, 1'b0, 5, 0, 12);
    run_pass(5, 64'd0, 0, 1'b0, 0, 0, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
